// File: rtl/ssm_pkg.sv
// Shared definitions for the execution-stage controller and the ALU bench:
// start codes, opcode values, alu_op encodings and the controller state enum.
package ssm_pkg;

    localparam logic [3:0] START_ALU   = 4'b0001;
    localparam logic [3:0] START_ALU_I = 4'b0010;

    localparam logic [3:0] OPC_ADD   = 4'b0001;
    localparam logic [3:0] OPC_SUB   = 4'b0010;
    localparam logic [3:0] OPC_NOT   = 4'b0011;
    localparam logic [3:0] OPC_AND   = 4'b0100;
    localparam logic [3:0] OPC_OR    = 4'b0101;
    localparam logic [3:0] OPC_XOR   = 4'b0110;
    localparam logic [3:0] OPC_XNOR  = 4'b0111;
    localparam logic [3:0] OPC_ADD_I = 4'b1000;
    localparam logic [3:0] OPC_SUB_I = 4'b1001;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NOT  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_XNOR = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_WB,
        ST_FIN,
        ST_WAIT_CLR
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder. Maps a 4-bit opcode plus the execution mode
// to an alu_op select and flags whether the opcode is valid in that mode.
// Illegal opcodes return alu_op 000.
//   opcode_i   : instruction opcode field
//   imm_mode_i : 1 = immediate-mode execution, 0 = register mode
//   alu_op_o   : ALU function select
//   legal_o    : opcode is valid for the mode
module alu_op_decode
    import ssm_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic       imm_mode_i,
    output logic [2:0] alu_op_o,
    output logic       legal_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b0;
        if (imm_mode_i) begin
            case (opcode_i)
                OPC_ADD_I: begin alu_op_o = ALU_ADD; legal_o = 1'b1; end
                OPC_SUB_I: begin alu_op_o = ALU_SUB; legal_o = 1'b1; end
                default:   ;
            endcase
        end else begin
            case (opcode_i)
                OPC_ADD:  begin alu_op_o = ALU_ADD;  legal_o = 1'b1; end
                OPC_SUB:  begin alu_op_o = ALU_SUB;  legal_o = 1'b1; end
                OPC_NOT:  begin alu_op_o = ALU_NOT;  legal_o = 1'b1; end
                OPC_AND:  begin alu_op_o = ALU_AND;  legal_o = 1'b1; end
                OPC_OR:   begin alu_op_o = ALU_OR;   legal_o = 1'b1; end
                OPC_XOR:  begin alu_op_o = ALU_XOR;  legal_o = 1'b1; end
                OPC_XNOR: begin alu_op_o = ALU_XNOR; legal_o = 1'b1; end
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_fsm.sv
// Execution-stage controller for register/immediate ALU instructions.
// Sequences operand A, operand B, compute and write-back over the shared bus,
// then pulses done (with illegal when the opcode does not fit the start code).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a start code; latches IR fields on a valid one
// RD_A      | register rs drives bus, ALU A loads
// RD_B      | rt (register mode) or imm (immediate mode) drives bus, B loads
// EXEC      | result register G loads ALU output
// WB        | G drives bus, register rd is written
// FIN       | done pulse (+ illegal); leave only once start_code is zero
// WAIT_CLR  | busy, no enables; waits for start_code to clear
//
// Ports: clock/reset (sync, active-high); start_code, instr from fetch;
// register-file, immediate, ALU and status controls out.
module alu_exec_fsm
    import ssm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int REG_SEL_W  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            start_code,
    input  logic [15:0]           instr,
    output logic [REG_SEL_W-1:0]  reg_read_sel,
    output logic                  reg_out_en,
    output logic [DATA_WIDTH-1:0] imm_data,
    output logic                  imm_out_en,
    output logic                  alu_a_in_en,
    output logic                  alu_b_in_en,
    output logic [2:0]            alu_op,
    output logic                  alu_result_in_en,
    output logic                  alu_result_out_en,
    output logic [REG_SEL_W-1:0]  reg_write_sel,
    output logic                  reg_in_en,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    state_e     state_q, state_d;
    logic [3:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       imm_mode_q, imm_mode_d;
    logic       illegal_q, illegal_d;

    logic       start_valid;
    logic       start_imm;
    logic [2:0] dec_op;
    logic       dec_legal;

    assign start_valid = (start_code == START_ALU) || (start_code == START_ALU_I);
    assign start_imm   = (start_code == START_ALU_I);

    // Decodes the live IR so legality is known at the sampling edge.
    alu_op_decode u_dec (
        .opcode_i   (instr[15:12]),
        .imm_mode_i (start_imm),
        .alu_op_o   (dec_op),
        .legal_o    (dec_legal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            alu_op_q   <= '0;
            imm_mode_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            alu_op_q   <= alu_op_d;
            imm_mode_q <= imm_mode_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        rd_d              = rd_q;
        rs_d              = rs_q;
        rt_d              = rt_q;
        alu_op_d          = alu_op_q;
        imm_mode_d        = imm_mode_q;
        illegal_d         = illegal_q;

        reg_read_sel      = '0;
        reg_out_en        = 1'b0;
        imm_out_en        = 1'b0;
        alu_a_in_en       = 1'b0;
        alu_b_in_en       = 1'b0;
        alu_op            = alu_op_q;
        alu_result_in_en  = 1'b0;
        alu_result_out_en = 1'b0;
        reg_write_sel     = '0;
        reg_in_en         = 1'b0;
        busy              = 1'b1;
        done              = 1'b0;
        illegal           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy   = 1'b0;
                alu_op = ALU_ADD;
                if (start_valid) begin
                    rd_d       = instr[11:8];
                    rs_d       = instr[7:4];
                    rt_d       = instr[3:0];
                    imm_mode_d = start_imm;
                    alu_op_d   = dec_op;
                    illegal_d  = !dec_legal;
                    state_d    = dec_legal ? ST_RD_A : ST_FIN;
                end
            end
            ST_RD_A: begin
                reg_read_sel = REG_SEL_W'(rs_q);
                reg_out_en   = 1'b1;
                alu_a_in_en  = 1'b1;
                state_d      = ST_RD_B;
            end
            ST_RD_B: begin
                alu_b_in_en = 1'b1;
                if (imm_mode_q) begin
                    imm_out_en = 1'b1;
                end else begin
                    reg_read_sel = REG_SEL_W'(rt_q);
                    reg_out_en   = 1'b1;
                end
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_result_in_en = 1'b1;
                state_d          = ST_WB;
            end
            ST_WB: begin
                alu_result_out_en = 1'b1;
                reg_write_sel     = REG_SEL_W'(rd_q);
                reg_in_en         = 1'b1;
                state_d           = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                illegal = illegal_q;
                state_d = (start_code == 4'b0000) ? ST_IDLE : ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (start_code == 4'b0000) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imm_data = DATA_WIDTH'(rt_q);

endmodule

// File: tb/tb_alu_exec_fsm.sv
module tb_alu_exec_fsm;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  start_code;
    logic [15:0] instr;
    logic [3:0]  reg_read_sel;
    logic        reg_out_en;
    logic [15:0] imm_data;
    logic        imm_out_en;
    logic        alu_a_in_en;
    logic        alu_b_in_en;
    logic [2:0]  alu_op;
    logic        alu_result_in_en;
    logic        alu_result_out_en;
    logic [3:0]  reg_write_sel;
    logic        reg_in_en;
    logic        busy;
    logic        done;
    logic        illegal;

    int tests = 0;
    int fails = 0;
    logic [3:0] m_imm = 4'h0;  // model of the latched imm4 field

    always #5 clock = ~clock;

    alu_exec_fsm #(.DATA_WIDTH(16), .REG_SEL_W(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .start_code        (start_code),
        .instr             (instr),
        .reg_read_sel      (reg_read_sel),
        .reg_out_en        (reg_out_en),
        .imm_data          (imm_data),
        .imm_out_en        (imm_out_en),
        .alu_a_in_en       (alu_a_in_en),
        .alu_b_in_en       (alu_b_in_en),
        .alu_op            (alu_op),
        .alu_result_in_en  (alu_result_in_en),
        .alu_result_out_en (alu_result_out_en),
        .reg_write_sel     (reg_write_sel),
        .reg_in_en         (reg_in_en),
        .busy              (busy),
        .done              (done),
        .illegal           (illegal)
    );

    logic [36:0] obs;
    assign obs = {reg_read_sel, reg_out_en, imm_data, imm_out_en, alu_a_in_en,
                  alu_b_in_en, alu_op, alu_result_in_en, alu_result_out_en,
                  reg_write_sel, reg_in_en, busy, done, illegal};

    // Reference legality/op table: {legal, alu_op}
    function automatic logic [3:0] ref_decode(input logic imm_mode, input logic [3:0] opc);
        if (!imm_mode && opc >= 4'd1 && opc <= 4'd7) return {1'b1, 3'(opc - 4'd1)};
        if (imm_mode && (opc == 4'd8 || opc == 4'd9)) return {1'b1, 3'(opc - 4'd8)};
        return 4'b0000;
    endfunction

    // Expected outputs for cycle phase ph after the start sample:
    // 0 idle, 1 read A, 2 read B, 3 compute, 4 write-back, 5 finish, 6 waiting for clear
    function automatic logic [36:0] exp_vec(input int ph, input logic imm_mode,
                                            input logic [3:0] rs, input logic [3:0] rt,
                                            input logic [3:0] rd, input logic [2:0] op,
                                            input logic ill, input logic [3:0] limm);
        logic [3:0] rsel = 4'h0, wsel = 4'h0;
        logic ro = 0, io = 0, a = 0, b = 0, ri = 0, rout = 0, win = 0, bz = 1, dn = 0, il = 0;
        logic [2:0] o = (ph == 0) ? 3'b000 : op;
        case (ph)
            0: bz = 0;
            1: begin rsel = rs; ro = 1; a = 1; end
            2: begin b = 1; if (imm_mode) io = 1; else begin rsel = rt; ro = 1; end end
            3: ri = 1;
            4: begin rout = 1; wsel = rd; win = 1; end
            5: begin dn = 1; il = ill; end
            default: ;
        endcase
        return {rsel, ro, {12'h000, limm}, io, a, b, o, ri, rout, wsel, win, bz, dn, il};
    endfunction

    task automatic check(input string tag, input logic [36:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start code, hold it nonzero for `hold` cycles, check every cycle until idle.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [15:0] ins,
                          input int hold, input bit scramble_ir);
        logic [3:0] d;
        logic       lg, im;
        int         fin, ph;
        im  = (code == 4'b0010);
        d   = ref_decode(im, ins[15:12]);
        lg  = d[3];
        fin = lg ? 5 : 1;
        m_imm = ins[3:0];
        start_code = code;
        instr      = ins;
        for (int c = 1; c < 40; c++) begin
            @(posedge clock); #1;
            if (c <= fin) ph = lg ? c : 5;
            else if (c - 1 < hold) ph = 6;
            else ph = 0;
            check(tag, exp_vec(ph, im, ins[7:4], ins[3:0], ins[11:8], d[2:0], !lg, m_imm));
            start_code = (c < hold) ? code : 4'b0000;
            if (scramble_ir) instr = 16'($urandom);
            if (ph == 0) break;
        end
    endtask

    initial begin
        reset = 1'b1;
        start_code = 4'b0000;
        instr = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", exp_vec(0, 0, 0, 0, 0, 0, 0, 4'h0));
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_after_reset", exp_vec(0, 0, 0, 0, 0, 0, 0, 4'h0));

        run_op("reg_add", 4'b0001, 16'h1213, 1, 1'b0);
        run_op("imm_sub", 4'b0010, 16'h9455, 1, 1'b1);
        run_op("held_code", 4'b0001, 16'h1213, 8, 1'b0);
        run_op("illegal_op", 4'b0001, 16'hC123, 1, 1'b0);
        run_op("imm_in_reg_mode", 4'b0001, 16'h8A21, 3, 1'b0);
        run_op("reg_in_imm_mode", 4'b0010, 16'h3A21, 1, 1'b0);

        start_code = 4'b0100;
        instr = 16'h1213;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("bad_code_idle", exp_vec(0, 0, 0, 0, 0, 0, 0, m_imm));
        end
        start_code = 4'b0000;

        // Reset during compute: nothing written, everything cleared.
        m_imm = 4'h5;
        start_code = 4'b0001;
        instr = 16'h2345;
        @(posedge clock); #1;
        check("rst_rd_a", exp_vec(1, 0, 4'h4, 4'h5, 4'h3, 3'b001, 0, m_imm));
        start_code = 4'b0000;
        @(posedge clock); #1;
        check("rst_rd_b", exp_vec(2, 0, 4'h4, 4'h5, 4'h3, 3'b001, 0, m_imm));
        @(posedge clock); #1;
        check("rst_exec", exp_vec(3, 0, 4'h4, 4'h5, 4'h3, 3'b001, 0, m_imm));
        reset = 1'b1;
        m_imm = 4'h0;
        @(posedge clock); #1;
        check("rst_cleared", exp_vec(0, 0, 0, 0, 0, 0, 0, m_imm));
        reset = 1'b0;
        @(posedge clock); #1;
        check("rst_stays_idle", exp_vec(0, 0, 0, 0, 0, 0, 0, m_imm));

        // Reset and valid code together: code must not be latched.
        reset = 1'b1;
        start_code = 4'b0001;
        instr = 16'h1FFF;
        @(posedge clock); #1;
        check("rst_vs_code", exp_vec(0, 0, 0, 0, 0, 0, 0, m_imm));
        reset = 1'b0;
        start_code = 4'b0000;
        @(posedge clock); #1;
        check("rst_vs_code_after", exp_vec(0, 0, 0, 0, 0, 0, 0, m_imm));

        for (int n = 0; n < 30; n++) begin
            logic [3:0] code;
            logic [15:0] ins;
            code = ($urandom_range(0, 1) == 0) ? 4'b0001 : 4'b0010;
            ins  = 16'($urandom);
            if ($urandom_range(0, 3) != 0)
                ins[15:12] = (code == 4'b0010) ? 4'($urandom_range(8, 9)) : 4'($urandom_range(1, 7));
            run_op("random_op", code, ins, int'($urandom_range(1, 8)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
